// File: rtl/riscv_step_sequencer.sv
// Multi-cycle sequencer for the single-cycle RISC-V datapath: fetch over req/ack, one dp_step per instruction.
// Optional single-step mode (step_req port, PAUSE state) is enabled by defining SEQ_SINGLE_STEP_EN.
module riscv_step_sequencer #(
  parameter int MEM_WAIT      = 2,
  parameter int FETCH_TIMEOUT = 16,
  parameter int MAX_INSTR     = 0,
  parameter int COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step_req,
`endif
  input  logic [31:0]        pc_in,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        dp_instr,
  output logic               dp_step,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  localparam int WW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    IDLE, FETCH, CHECK, EXEC, MEMW, NEXT, HALT, FAULT, PAUSE
  } state_t;

  state_t               state, state_d;
  logic [TW-1:0]        tmo_cnt, tmo_d;
  logic [WW-1:0]        wait_cnt, wait_d;
  logic                 req_d, step_d, busy_d, halted_d, fault_d;
  logic [31:0]          addr_d, instr_d;
  logic [COUNT_W-1:0]   cnt_d;
  logic                 is_mem, limit_hit;

  assign is_mem    = (dp_instr[6:0] == 7'b0000011) || (dp_instr[6:0] == 7'b0100011);
  assign limit_hit = (MAX_INSTR != 0) && (instr_count == COUNT_W'(MAX_INSTR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      dp_instr    <= NOP;
      dp_step     <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      instr_count <= '0;
      tmo_cnt     <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_d;
      imem_req    <= req_d;
      imem_addr   <= addr_d;
      dp_instr    <= instr_d;
      dp_step     <= step_d;
      busy        <= busy_d;
      halted      <= halted_d;
      fault       <= fault_d;
      instr_count <= cnt_d;
      tmo_cnt     <= tmo_d;
      wait_cnt    <= wait_d;
    end
  end

  always_comb begin
    state_d  = state;
    req_d    = imem_req;
    addr_d   = imem_addr;
    instr_d  = dp_instr;
    step_d   = 1'b0;
    halted_d = halted;
    fault_d  = fault;
    cnt_d    = instr_count;
    tmo_d    = tmo_cnt;
    wait_d   = wait_cnt;
    case (state)
      // Any launch from rest starts a fresh run: count and status flags are cleared.
      IDLE, HALT, FAULT: begin
        if (start) begin
          state_d  = FETCH;
          req_d    = 1'b1;
          addr_d   = pc_in;
          cnt_d    = '0;
          halted_d = 1'b0;
          fault_d  = 1'b0;
          tmo_d    = '0;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          req_d   = 1'b0;
          state_d = CHECK;
        end else if (tmo_cnt == TW'(FETCH_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          tmo_d = tmo_cnt + TW'(1);
        end
      end
      CHECK: begin
        if (dp_instr == EBREAK) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          state_d = EXEC;
          step_d  = 1'b1;
          if (instr_count != '1) cnt_d = instr_count + COUNT_W'(1);
        end
      end
      EXEC: begin
        if (is_mem && (MEM_WAIT > 0)) begin
          state_d = MEMW;
          wait_d  = '0;
        end else begin
          state_d = NEXT;
        end
      end
      MEMW: begin
        if (wait_cnt == WW'(MEM_WAIT - 1)) state_d = NEXT;
        else wait_d = wait_cnt + WW'(1);
      end
      NEXT: begin
        // stop and the instruction limit collapse into one HALT transition
        if (stop || limit_hit) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
`ifdef SEQ_SINGLE_STEP_EN
          state_d = PAUSE;
`else
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = pc_in;
          tmo_d   = '0;
`endif
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      PAUSE: begin
        if (stop) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (step_req) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = pc_in;
          tmo_d   = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FETCH) || (state_d == CHECK) || (state_d == EXEC) ||
             (state_d == MEMW)  || (state_d == NEXT)  || (state_d == PAUSE);
  end

endmodule

// File: tb/tb_riscv_step_sequencer.sv
// Bench for riscv_step_sequencer: memory responder and PC model driven per cycle, results
// compared with an instruction-level reference of the program run.
module tb_riscv_step_sequencer;
  localparam int MEM_WAIT      = 2;
  localparam int FETCH_TIMEOUT = 16;
  localparam int MAX_INSTR     = 3;
  localparam int COUNT_W       = 16;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADD    = 32'h0020_81b3;
  localparam logic [31:0] OR_I   = 32'h0020_e1b3;
  localparam logic [31:0] LB     = 32'h0000_8083;
  localparam logic [31:0] SB     = 32'h0011_0023;

  logic clk, reset, start, stop, imem_req, imem_ack, dp_step, busy, halted, fault;
  logic [31:0] pc_in, imem_addr, imem_rdata, dp_instr;
  logic [COUNT_W-1:0] instr_count;

  int checks, errors;
  logic [31:0] prog [64];
  int dly [64];
  int rise_cyc [64];
  int step_cyc [64];
  logic [31:0] rise_addr [64];
  logic [31:0] step_ins [64];
  int n_rise, n_step, cyc_n, wcnt, stop_fetch_k, stop_step_k;
  bit req_q, noise;

  riscv_step_sequencer #(
    .MEM_WAIT(MEM_WAIT), .FETCH_TIMEOUT(FETCH_TIMEOUT),
    .MAX_INSTR(MAX_INSTR), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pc_in(pc_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dp_instr(dp_instr), .dp_step(dp_step),
    .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, record events, then drive memory responder / PC model.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    if (imem_req && !req_q && n_rise < 64) begin
      rise_cyc[n_rise]  = cyc_n;
      rise_addr[n_rise] = imem_addr;
      n_rise++;
      if (stop_fetch_k > 0 && n_rise == stop_fetch_k) stop = 1'b1;
    end
    req_q = imem_req;
    if (dp_step && n_step < 64) begin
      step_cyc[n_step] = cyc_n;
      step_ins[n_step] = dp_instr;
      n_step++;
      pc_in = pc_in + 32'd4;
      if (stop_step_k > 0 && n_step == stop_step_k) stop = 1'b1;
    end
    if (imem_req) begin
      if (wcnt >= dly[(n_rise > 0) ? n_rise - 1 : 0]) begin
        imem_ack   = 1'b1;
        imem_rdata = prog[imem_addr[7:2]];
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt       = 0;
      imem_ack   = noise && ($urandom_range(3) == 0);
      imem_rdata = $urandom;
    end
    if (noise) start = busy && ($urandom_range(1) == 1);
  endtask

  task automatic init_run();
    n_rise = 0; n_step = 0; cyc_n = 0; wcnt = 0; req_q = 1'b0; stop = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) begin
      prog[i] = NOP;
      dly[i]  = 0;
    end
    stop_fetch_k = 0; stop_step_k = 0; noise = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " req"},    32'(imem_req), 32'd0);
    chk({tag, " addr"},   imem_addr, 32'd0);
    chk({tag, " instr"},  dp_instr, NOP);
    chk({tag, " step"},   32'(dp_step), 32'd0);
    chk({tag, " busy"},   32'(busy), 32'd0);
    chk({tag, " halted"}, 32'(halted), 32'd0);
    chk({tag, " fault"},  32'(fault), 32'd0);
    chk({tag, " count"},  32'(instr_count), 32'd0);
  endtask

  // Launch the program at pc0, run to rest, and compare with the instruction-level reference.
  task automatic run_and_check(input string tag, input logic [31:0] pc0);
    logic [31:0] e_addr [8];
    logic [31:0] e_ins [8];
    bit          e_mem [8];
    logic [31:0] pc, ins;
    int en, enf, stop_k, guard;
    pc = pc0; en = 0; enf = 0;
    stop_k = (stop_fetch_k > 0) ? stop_fetch_k : stop_step_k;
    for (int g = 0; g < 8; g++) begin
      e_addr[enf] = pc;
      ins = prog[pc[7:2]];
      enf++;
      if (ins == EBREAK) break;
      e_ins[en] = ins;
      e_mem[en] = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h23);
      en++;
      pc = pc + 32'd4;
      if (stop_k > 0 && en >= stop_k) break;
      if (en == MAX_INSTR) break;
    end

    init_run();
    pc_in = pc0;
    start = 1'b1;
    cyc();
    if (!noise) start = 1'b0;
    guard = 0;
    while (busy && guard < 300) begin
      cyc();
      guard++;
    end
    chk({tag, " done"}, 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) cyc();
    chk({tag, " halted"}, 32'(halted), 32'd1);
    chk({tag, " fault"},  32'(fault), 32'd0);
    chk({tag, " count"},  32'(instr_count), 32'(en));
    chk({tag, " nsteps"}, 32'(n_step), 32'(en));
    chk({tag, " nfetch"}, 32'(n_rise), 32'(enf));
    for (int i = 0; i < enf && i < n_rise; i++)
      chk($sformatf("%s addr%0d", tag, i), rise_addr[i], e_addr[i]);
    for (int i = 0; i < en && i < n_step && i < n_rise; i++) begin
      chk($sformatf("%s ins%0d", tag, i), step_ins[i], e_ins[i]);
      chk($sformatf("%s lat%0d", tag, i), 32'(step_cyc[i] - rise_cyc[i]), 32'(dly[i] + 2));
      if (i + 1 < enf && i + 1 < n_rise)
        chk($sformatf("%s gap%0d", tag, i), 32'(rise_cyc[i + 1] - step_cyc[i]),
            32'(2 + (e_mem[i] ? MEM_WAIT : 0)));
    end
  endtask

  initial begin
    int guard, fcyc;
    logic [31:0] w;
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pc_in = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    clear_prog();
    init_run();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    cyc();
    check_reset_vals("idle");

    // ADD, OR, EBREAK with zero-wait ack
    clear_prog();
    prog[0] = ADD; prog[1] = OR_I; prog[2] = EBREAK;
    run_and_check("t1", 32'h0);

    // load followed by EBREAK: two wait cycles plus NEXT before the next fetch
    clear_prog();
    prog[0] = LB; prog[1] = EBREAK;
    run_and_check("t2", 32'h0);

    // endless NOPs stop at the instruction limit
    clear_prog();
    run_and_check("t4", 32'h0);

    // stop raised during the second fetch
    clear_prog();
    prog[0] = ADD; prog[1] = OR_I; prog[2] = ADD; prog[3] = ADD;
    stop_fetch_k = 2;
    run_and_check("t5", 32'h0);

    // fetch timeout, then restart from FAULT at a new PC
    clear_prog();
    dly[0] = 1000;
    init_run();
    pc_in = 32'h0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    guard = 0;
    while (!fault && guard < 40) begin
      cyc();
      guard++;
    end
    fcyc = cyc_n;
    chk("tmo fault",  32'(fault), 32'd1);
    chk("tmo gap",    32'(fcyc - rise_cyc[0]), 32'(FETCH_TIMEOUT));
    chk("tmo req",    32'(imem_req), 32'd0);
    chk("tmo busy",   32'(busy), 32'd0);
    chk("tmo halted", 32'(halted), 32'd0);
    prog[16] = EBREAK;
    pc_in = 32'h40;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("tmo clear", 32'(fault), 32'd0);
    chk("tmo refetch req", 32'(imem_req), 32'd1);
    chk("tmo refetch addr", imem_addr, 32'h40);
    guard = 0;
    while (busy && guard < 40) begin
      cyc();
      guard++;
    end
    chk("tmo end halted", 32'(halted), 32'd1);
    chk("tmo end count", 32'(instr_count), 32'd0);

    // reset in MEMW, then reset in a stalled FETCH
    clear_prog();
    prog[2] = LB; prog[3] = EBREAK;
    init_run();
    pc_in = 32'h8;
    start = 1'b1;
    cyc();
    start = 1'b0;
    guard = 0;
    while (n_step == 0 && guard < 20) begin
      cyc();
      guard++;
    end
    cyc();
    chk("rst memw pre busy", 32'(busy), 32'd1);
    chk("rst memw pre req", 32'(imem_req), 32'd0);
    reset = 1'b1;
    #1;
    check_reset_vals("rst memw");
    #1 reset = 1'b0;
    init_run();
    dly[0] = 5;
    pc_in = 32'h20;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("rst fetch pre req", 32'(imem_req), 32'd1);
    chk("rst fetch pre addr", imem_addr, 32'h20);
    reset = 1'b1;
    #1;
    check_reset_vals("rst fetch");
    #1 reset = 1'b0;
    repeat (3) cyc();
    check_reset_vals("rst idle");

    // randomized programs, ack latencies, stop points and spurious ack/start noise
    for (int r = 0; r < 25; r++) begin
      clear_prog();
      for (int i = 0; i < 64; i++) begin
        case ($urandom_range(7))
          0: prog[i] = ADD;
          1: prog[i] = OR_I;
          2: prog[i] = LB;
          3: prog[i] = SB;
          4: prog[i] = NOP;
          5: prog[i] = EBREAK;
          default: begin
            w = $urandom;
            prog[i] = (w == EBREAK) ? NOP : w;
          end
        endcase
        dly[i] = $urandom_range(3);
      end
      case ($urandom_range(3))
        1: stop_fetch_k = $urandom_range(3, 1);
        2: stop_step_k  = $urandom_range(3, 1);
        default: ;
      endcase
      noise = 1'b1;
      run_and_check($sformatf("rnd%0d", r), 32'($urandom_range(32)) << 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_step_sequencer.md
Name: riscv_step_sequencer

Overview:
- Multi-cycle controller that sequences the single-cycle RISC-V datapath.
- Fetches each instruction from instruction memory over a req/ack handshake, using the datapath's current PC as the address.
- Presents the instruction to the datapath and issues exactly one clock-enable pulse per instruction.
- Inserts wait cycles after loads and stores, counts retired instructions, and halts on EBREAK, on an instruction limit or on a stop request.

Parameters:
- MEM_WAIT, 2: extra cycles held after LB/SB (opcode 0000011/0100011) execute; 0 = none.
- FETCH_TIMEOUT, 16: cycles FETCH may wait for imem_ack before faulting; must be ≥1.
- MAX_INSTR, 0: halt after this many retired instructions; 0 = unlimited.
- COUNT_W, 16: width of instr_count.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  level-sampled; begins or resumes execution from IDLE, HALT or FAULT
- stop  in  1  request to halt after the current instruction
- pc_in  in  32  datapath PC
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  fetch done; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction
- dp_instr  out  32  instruction driven to the datapath
- dp_step  out  1  one-cycle datapath enable
- busy  out  1  high in FETCH/CHECK/EXEC/MEMW/NEXT
- halted  out  1  high in HALT
- fault  out  1  high in FAULT
- instr_count  out  COUNT_W  retired-instruction count

Behaviour:
- Reset (async) values:
  - state=IDLE
  - imem_req=0, imem_addr=0
  - dp_instr=32'h00000013 (NOP)
  - dp_step=0, busy=0, halted=0, fault=0
  - instr_count=0
  - timeout and wait counters=0
- All outputs are registered. Reset asserted in any state returns to IDLE within the same cycle; an in-flight request is dropped.
- IDLE: start=1 → FETCH. On entry to FETCH: imem_req=1, imem_addr=pc_in, instr_count=0, halted=0, fault=0.
- FETCH:
  - imem_req and imem_addr stay stable until ack.
  - On imem_ack: dp_instr<=imem_rdata, imem_req<=0, go to CHECK.
  - Timeout counter increments every cycle without ack. When it reaches FETCH_TIMEOUT: imem_req<=0, fault<=1, go to FAULT.
  - imem_ack outside FETCH is ignored.
- CHECK:
  - dp_instr==32'h00100073 (EBREAK) → HALT. EBREAK is not executed and not counted.
  - Otherwise → EXEC.
- EXEC:
  - dp_step=1 for exactly this cycle; instr_count+1, saturating at all-ones.
  - If opcode is 0000011 or 0100011 and MEM_WAIT>0 → MEMW; else → NEXT.
- MEMW: holds exactly MEM_WAIT cycles with dp_step=0, then → NEXT.
- NEXT: pc_in reflects the updated PC in this state. Checks are applied in priority order:
  - stop=1 → HALT.
  - MAX_INSTR≠0 and instr_count==MAX_INSTR → HALT.
  - Otherwise → FETCH with imem_addr=pc_in.
- stop is sampled only in NEXT. The in-flight instruction always completes; stop asserted in any other state is held off until NEXT.
- HALT: halted=1, busy=0. start=1 → FETCH as from IDLE (count cleared).
- FAULT: fault=1 (sticky), busy=0. start=1 → FETCH as from IDLE, clearing fault.
- Minimum cost per non-memory instruction (zero-wait ack) is 4 cycles: FETCH, CHECK, EXEC, NEXT.
- Simultaneous events:
  - start during busy states is ignored.
  - stop and instruction limit both true in NEXT → HALT (single transition).

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input step_req (1 bit) and state PAUSE.
  - NEXT goes to PAUSE instead of FETCH.
  - PAUSE holds busy=1 and waits for a step_req high cycle, then → FETCH with imem_addr=pc_in.
  - stop in PAUSE → HALT.
  - The limit and EBREAK rules are unchanged.
- Undefined: no step_req port, no PAUSE state; behaviour exactly as above.

Test Plan:
1. Reset, start=1, imem returns ADD, OR, EBREAK with zero-wait ack, pc_in advances 0→4→8 → dp_step pulses exactly 2 times, imem_addr 0,4,8, halted=1, instr_count=2.
2. LB at pc 0 with MEM_WAIT=2 → dp_step at cycle N, next imem_req rises at cycle N+4 (two MEMW cycles plus NEXT), count=1.
3. imem_ack never asserted, FETCH_TIMEOUT=16 → fault=1 and imem_req=0 exactly 16 cycles after req rose; start=1 → fault clears, refetch at pc_in.
4. MAX_INSTR=3 with an endless NOP stream → exactly 3 dp_step pulses, halted=1, instr_count=3.
5. stop asserted during FETCH of the 2nd instruction → 2nd instruction executes (count=2), then HALT with no further imem_req.
6. Reset asserted mid-MEMW with imem_req low, then mid-FETCH with req high → all outputs return to reset values immediately; dp_instr=32'h00000013.
